// File: rtl/fheep_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fheep_pkg
// Purpose  : Shared XIF result struct and its packed width for the FPU subsystem.
// Revision : 1.0
// ============================================================================
package fheep_pkg;

  localparam int X_ID_WIDTH = 4;
  localparam int X_DATA_W   = 32;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [X_DATA_W-1:0]   data;
    logic [4:0]            rd;
    logic                  we;
    logic [2:0]            ecswe;
    logic [5:0]            ecsdata;
    logic                  exc;
    logic [5:0]            exccode;
    logic                  err;
    logic                  dbg;
  } x_result_t;

  localparam int X_RESULT_W = $bits(x_result_t);

endpackage
`default_nettype wire

// File: rtl/fpu_ss_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fpu_ss_result_buffer
// Purpose  : Elastic FIFO on the XIF result channel with occupancy and
//            sticky protocol-violation reporting.
// Revision : 1.0
// ============================================================================
module fpu_ss_result_buffer
  import fheep_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int RESULT_W = X_RESULT_W,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                result_valid_i,
  output logic                result_ready_o,
  input  logic [RESULT_W-1:0] result_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [RESULT_W-1:0] result_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                drop_err_o
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [RESULT_W-1:0] r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [CNT_W-1:0]    r_count;
  logic                r_held;
  logic                r_drop_err;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ready depends only on registered occupancy, never on result_ready_i.
  assign result_ready_o = !w_full && !rst_i;
  assign result_valid_o = !w_empty;
  assign result_o       = r_mem[r_rptr];
  assign count_o        = r_count;
  assign full_o         = w_full;
  assign empty_o        = w_empty;
  assign drop_err_o     = r_drop_err;

  assign w_push = result_valid_i && result_ready_o;
  assign w_pop  = result_valid_o && result_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= result_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_w'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A held-off offer that is withdrawn next cycle means a result was lost upstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_held     <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_held <= result_valid_i && !result_ready_o;
      if (r_held && !result_valid_i) begin
        r_drop_err <= 1'b1;
      end
    end
  end

  a_head_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (result_valid_o && !result_ready_i) |=> $stable(result_o));

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_fpu_ss_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_ss_result_buffer
// Purpose  : Directed and scoreboard-driven checks of the result buffer.
// Revision : 1.0
// ============================================================================
module tb_fpu_ss_result_buffer;
  import fheep_pkg::*;

  localparam int DEPTH = 4;
  localparam int RW    = X_RESULT_W;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          result_valid_i = 1'b0;
  logic          result_ready_o;
  logic [RW-1:0] result_i = '0;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  logic [RW-1:0] result_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          empty_o;
  logic          drop_err_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] q[$];
  logic          exp_held = 1'b0;
  logic          exp_drop = 1'b0;
  int            n_push = 0;
  int            n_pop  = 0;

  fpu_ss_result_buffer #(.DEPTH(DEPTH), .RESULT_W(RW), .CNT_W(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .result_valid_i (result_valid_i),
    .result_ready_o (result_ready_o),
    .result_i       (result_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .count_o        (count_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .drop_err_o     (drop_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk(input logic [3:0] id, input logic [31:0] data);
    x_result_t r;
    r = '0;
    r.id   = id;
    r.data = data;
    r.rd   = 5'(id + 4'd1);
    r.we   = 1'b1;
    return RW'(r);
  endfunction

  // One clock cycle: drive, check against the model, then advance model state.
  task automatic cycle(input logic v, input logic [RW-1:0] d, input logic rdy);
    logic e_ready, e_valid, push, pop;
    result_valid_i = v;
    result_i       = d;
    result_ready_i = rdy;
    #1;
    e_ready = (q.size() < DEPTH);
    e_valid = (q.size() != 0);
    check("ready", 64'(result_ready_o), 64'(e_ready));
    check("valid", 64'(result_valid_o), 64'(e_valid));
    check("count", 64'(count_o), 64'(q.size()));
    check("full",  64'(full_o),  64'(q.size() == DEPTH));
    check("empty", 64'(empty_o), 64'(q.size() == 0));
    check("drop",  64'(drop_err_o), 64'(exp_drop));
    if (e_valid) check("data", 64'(result_o), 64'(q[0]));
    push = v && e_ready;
    pop  = e_valid && rdy;
    @(posedge clk_i);
    if (pop) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (push) begin
      q.push_back(d);
      n_push++;
    end
    if (exp_held && !v) exp_drop = 1'b1;
    exp_held = v && !e_ready;
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    check("rst_valid", 64'(result_valid_o), 64'(0));
    check("rst_count", 64'(count_o), 64'(0));
    check("rst_empty", 64'(empty_o), 64'(1));
    check("rst_full",  64'(full_o),  64'(0));
    check("rst_ready", 64'(result_ready_o), 64'(0));
    check("rst_drop",  64'(drop_err_o), 64'(0));
    @(posedge clk_i);
    #1;
    check("rst_ready_hold", 64'(result_ready_o), 64'(0));
    rst_i = 1'b0;
    #1;
    check("rst_ready_after", 64'(result_ready_o), 64'(1));
    check("rst_count_after", 64'(count_o), 64'(0));
    q.delete();
    exp_held = 1'b0;
    exp_drop = 1'b0;
    n_push = 0;
    n_pop  = 0;
  endtask

  initial begin
    @(posedge clk_i);
    #1;
    do_reset();

    // Single result: presented one cycle after acceptance, count 1 then 0.
    cycle(1'b1, mk(4'd3, 32'h3F80_0000), 1'b1);
    check("single_payload", 64'(result_o), 64'(mk(4'd3, 32'h3F80_0000)));
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);

    // Fill under backpressure, 5th offer refused, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(4'(i), 32'hA000_0000 + 32'(i)), 1'b0);
    cycle(1'b1, mk(4'd4, 32'hDEAD_BEEF), 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("fill_order_id", 64'(result_o[RW-1 -: 4]), 64'(i));
      cycle(1'b0, '0, 1'b1);
    end
    check("drop_after_withdraw", 64'(drop_err_o), 64'(1));
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
    check("drop_sticky", 64'(drop_err_o), 64'(1));

    // Reset mid-stream with three entries stored.
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(4'(i + 8), 32'h1234_0000 + 32'(i)), 1'b0);
    do_reset();

    // Streaming at full rate.
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, mk(4'(i), 32'h4000_0000 ^ 32'(i * 7)), 1'b1);
      check("stream_cnt_le1", 64'(count_o <= 1), 64'(1));
    end
    cycle(1'b0, '0, 1'b1);
    check("stream_drained", 64'(empty_o), 64'(1));

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      logic [63:0] rnd;
      rnd = {32'($urandom), 32'($urandom)};
      cycle(1'($urandom_range(0, 1)), rnd[RW-1:0], 1'($urandom_range(0, 1)));
    end
    check("rand_count", 64'(count_o), 64'(n_push - n_pop));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
